// File: rtl/tp_ram_arbiter_pkg.sv
// rtl/tp_ram_arbiter_pkg.sv - shared constants, read-tag record and pointer helpers for tp_ram_arbiter
package tp_ram_arb_pkg;

    localparam int MAX_REQ           = 16;
    localparam int REQ_IDX_W         = $clog2(MAX_REQ);
    localparam int TP_RAM_OUTPUT_REG = 1;
    // Core array read takes two cycles; the tp_ram output register adds one more.
    localparam int DEF_RD_LATENCY    = 2 + TP_RAM_OUTPUT_REG;

    typedef struct packed {
        logic                 valid;
        logic [REQ_IDX_W-1:0] idx;
    } rd_tag_t;

    function automatic logic [REQ_IDX_W:0] rr_dist(input int j, input logic [REQ_IDX_W-1:0] ptr,
                                                   input int n);
        int d;
        d = j - int'(ptr);
        if (d < 0) d = d + n;
        return (REQ_IDX_W+1)'(d);
    endfunction

    function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx, input int n);
        int v;
        v = int'(idx) + 1;
        if (v >= n) v = 0;
        return REQ_IDX_W'(v);
    endfunction

endpackage

// File: rtl/tp_ram_arbiter_if.sv
// rtl/tp_ram_arbiter_if.sv - requester and RAM-side signal bundle for tp_ram_arbiter
interface tp_ram_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            wr_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]            wr_gnt;
    logic [NUM_REQ-1:0]            rd_req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_REQ-1:0]            rd_gnt;
    logic [NUM_REQ-1:0]            rd_valid;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          ram_en_wr;
    logic [ADDR_WIDTH-1:0]         ram_addr_wr;
    logic [DATA_WIDTH-1:0]         ram_data_wr;
    logic                          ram_en_rd;
    logic [ADDR_WIDTH-1:0]         ram_addr_rd;
    logic [DATA_WIDTH-1:0]         ram_data_rd;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_rd,
        output wr_gnt, rd_gnt, rd_valid, rd_data,
        output ram_en_wr, ram_addr_wr, ram_data_wr, ram_en_rd, ram_addr_rd
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_data_rd,
        input  wr_gnt, rd_gnt, rd_valid, rd_data,
        input  ram_en_wr, ram_addr_wr, ram_data_wr, ram_en_rd, ram_addr_rd
    );

endinterface

// File: rtl/tp_ram_arbiter_rr_arbiter.sv
// rtl/tp_ram_arbiter_rr_arbiter.sv - round-robin arbiter: first request at/after pointer wins
module rr_arbiter
    import tp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 block,
    output logic [REQ_IDX_W-1:0] cand_idx,
    output logic                 gnt_any,
    output logic [NUM_REQ-1:0]   gnt
);

    logic [REQ_IDX_W-1:0] ptr;
    logic [REQ_IDX_W:0]   best;
    logic                 cand_vld;

    // Smallest upward distance from the pointer wins; wrap is folded into rr_dist.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        best     = '1;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (rr_dist(j, ptr, NUM_REQ) < best)) begin
                best     = rr_dist(j, ptr, NUM_REQ);
                cand_idx = REQ_IDX_W'(j);
                cand_vld = 1'b1;
            end
        end
    end

    assign gnt_any = cand_vld && !block && !rst;

    always_comb begin
        gnt = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt[j] = gnt_any && (cand_idx == REQ_IDX_W'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= rr_next(cand_idx, NUM_REQ);
        end
    end

endmodule

// File: rtl/tp_ram_arbiter.sv
// rtl/tp_ram_arbiter.sv - shares one tp_ram among requesters; TP_RAM_ARB_RAW_STALL_EN adds read-after-write stall
module tp_ram_arbiter
    import tp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    tp_ram_arbiter_if.slave  bus
);

    logic [REQ_IDX_W-1:0]  wr_cand;
    logic [REQ_IDX_W-1:0]  rd_cand;
    logic                  wr_any;
    logic                  rd_any;
    logic                  rd_block;
    logic [ADDR_WIDTH-1:0] wr_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;
    logic [ADDR_WIDTH-1:0] rd_addr_sel;
    rd_tag_t               tag_pipe [RD_LATENCY];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.wr_req),
        .block    (1'b0),
        .cand_idx (wr_cand),
        .gnt_any  (wr_any),
        .gnt      (bus.wr_gnt)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.rd_req),
        .block    (rd_block),
        .cand_idx (rd_cand),
        .gnt_any  (rd_any),
        .gnt      (bus.rd_gnt)
    );

    always_comb begin
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (wr_cand == REQ_IDX_W'(j)) begin
                wr_addr_sel = bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_cand == REQ_IDX_W'(j)) begin
                rd_addr_sel = bus.rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

`ifdef TP_RAM_ARB_RAW_STALL_EN
    // Hold back a read that would race the write landing this cycle.
    assign rd_block = bus.ram_en_wr && (rd_addr_sel == bus.ram_addr_wr);
`else
    assign rd_block = 1'b0;
`endif

    assign bus.rd_data = bus.ram_data_rd;

    // rd_valid is registered off the last tag stage, giving RD_LATENCY+1 from grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ram_en_wr   <= 1'b0;
            bus.ram_addr_wr <= '0;
            bus.ram_data_wr <= '0;
            bus.ram_en_rd   <= 1'b0;
            bus.ram_addr_rd <= '0;
            bus.rd_valid    <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            bus.ram_en_wr <= wr_any;
            if (wr_any) begin
                bus.ram_addr_wr <= wr_addr_sel;
                bus.ram_data_wr <= wr_data_sel;
            end
            bus.ram_en_rd <= rd_any;
            if (rd_any) begin
                bus.ram_addr_rd <= rd_addr_sel;
            end
            tag_pipe[0] <= '{valid: rd_any, idx: rd_cand};
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                bus.rd_valid[j] <= tag_pipe[RD_LATENCY-1].valid &&
                                   (tag_pipe[RD_LATENCY-1].idx == REQ_IDX_W'(j));
            end
        end
    end

endmodule

// File: tb/tb_tp_ram_arbiter.sv
// tb/tb_tp_ram_arbiter.sv - scoreboard bench for tp_ram_arbiter with a behavioural tp_ram
module tb_tp_ram_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int RDL = 3;
`ifdef TP_RAM_ARB_RAW_STALL_EN
    localparam int WAIT_BOUND = 8 * NR;
`else
    localparam int WAIT_BOUND = NR;
`endif

    typedef struct { int idx; logic [DW-1:0] data; int due; } rd_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int due; } wr_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_mem = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    rd_exp_t rdq[$];
    wr_exp_t wrq[$];
    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] shadow [2**AW];
    logic [DW-1:0] pipe   [RDL];

    int            m_wptr, m_rptr, mw, mr;
    logic          m_en_wr;
    logic [AW-1:0] m_addr_wr;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    rd_exp_t       re;
    wr_exp_t       we;

    tp_ram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tp_ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (bus.ram_en_wr) begin
            mem[bus.ram_addr_wr] <= bus.ram_data_wr;
        end
        pipe[0] <= bus.ram_en_rd ? mem[bus.ram_addr_rd] : '0;
        for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.ram_data_rd = pipe[RDL-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (req[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts grants and pushes expected RAM traffic and read returns.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("gnt_in_reset", {bus.wr_gnt, bus.rd_gnt}, '0);
            m_wptr  = 0;
            m_rptr  = 0;
            m_en_wr = 1'b0;
            rdq.delete();
            wrq.delete();
        end else begin
            mw = rr_pick(bus.wr_req, m_wptr);
            mr = rr_pick(bus.rd_req, m_rptr);
`ifdef TP_RAM_ARB_RAW_STALL_EN
            if (mr >= 0 && m_en_wr && bus.rd_addr[mr*AW +: AW] == m_addr_wr) mr = -1;
`endif
            chk("wr_gnt_model", bus.wr_gnt, onehot(mw));
            chk("rd_gnt_model", bus.rd_gnt, onehot(mr));
            if (mr >= 0) begin
                ma = bus.rd_addr[mr*AW +: AW];
                rdq.push_back('{idx: mr, data: shadow[ma], due: cyc + RDL + 1});
                m_rptr = (mr + 1) % NR;
            end
            m_en_wr = (mw >= 0);
            if (mw >= 0) begin
                ma = bus.wr_addr[mw*AW +: AW];
                md = bus.wr_data[mw*DW +: DW];
                shadow[ma] = md;
                wrq.push_back('{addr: ma, data: md, due: cyc + 1});
                m_addr_wr = ma;
                m_wptr = (mw + 1) % NR;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents RAM writes or read returns.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.rd_valid != '0) begin
                if (rdq.size() == 0) begin
                    chk("rd_valid_unexpected", bus.rd_valid, '0);
                end else begin
                    re = rdq.pop_front();
                    chk("rd_valid_idx", bus.rd_valid, onehot(re.idx));
                    chk("rd_data", bus.rd_data, re.data);
                    chk("rd_latency", cyc, re.due);
                end
            end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                re = rdq.pop_front();
                chk("rd_valid_missing", bus.rd_valid, onehot(re.idx));
            end
            if (bus.ram_en_wr) begin
                if (wrq.size() == 0) begin
                    chk("ram_en_wr_unexpected", bus.ram_en_wr, 1'b0);
                end else begin
                    we = wrq.pop_front();
                    chk("ram_wr_bus", {bus.ram_addr_wr, bus.ram_data_wr}, {we.addr, we.data});
                    chk("ram_wr_latency", cyc, we.due);
                end
            end else if (wrq.size() > 0 && wrq[0].due <= cyc) begin
                we = wrq.pop_front();
                chk("ram_en_wr_missing", bus.ram_en_wr, 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [NR-1:0] gw, gr;
    int            wwait [NR];
    int            rwait [NR];
    logic          got;

    initial begin
        bus.wr_req  = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;
        for (int i = 0; i < 2**AW; i++) shadow[i] = '0;
        for (int i = 0; i < NR; i++) begin wwait[i] = 0; rwait[i] = 0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {bus.wr_gnt, bus.rd_gnt, bus.rd_valid, bus.ram_en_wr, bus.ram_en_rd}, '0);
        chk("reset_bus", {bus.ram_addr_wr, bus.ram_data_wr, bus.ram_addr_rd}, '0);

        // Four writes: A0..A3 to addr 0..3, granted 0,1,2,3
        tick();
        rst = 1'b0;
        clr_mem = 1'b0;
        bus.wr_req = '1;
        for (int i = 0; i < NR; i++) begin
            bus.wr_addr[i*AW +: AW] = AW'(i);
            bus.wr_data[i*DW +: DW] = DW'(8'hA0 + i);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("dir_wr_gnt", bus.wr_gnt, onehot(k));
            if (k > 0) chk("dir_ram_wr", {bus.ram_en_wr, bus.ram_addr_wr, bus.ram_data_wr},
                           {1'b1, AW'(k-1), DW'(8'hA0 + k - 1)});
            tick();
            bus.wr_req[k] = 1'b0;
        end
        @(negedge clk);
        chk("dir_ram_wr_last", {bus.ram_en_wr, bus.ram_addr_wr, bus.ram_data_wr}, {1'b1, 4'd3, 8'hA3});

        // Four reads of addr 3,2,1,0
        tick();
        bus.rd_req = '1;
        for (int i = 0; i < NR; i++) bus.rd_addr[i*AW +: AW] = AW'(3 - i);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("dir_rd_gnt", bus.rd_gnt, onehot(k));
            tick();
            bus.rd_req[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("dir_rd_valid", bus.rd_valid, onehot(k));
            chk("dir_rd_data", bus.rd_data, DW'(8'hA3 - k));
            tick();
        end

        // Requester 2 alone for 5 cycles, then 0 and 2 together from pointer 3
        bus.rd_req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("dir_rd_solo2", bus.rd_gnt, 4'b0100);
            tick();
        end
        bus.rd_req = 4'b0101;
        @(negedge clk);
        chk("dir_rd_wrap0", bus.rd_gnt, 4'b0001);
        tick();
        bus.rd_req[0] = 1'b0;
        @(negedge clk);
        chk("dir_rd_then2", bus.rd_gnt, 4'b0100);
        tick();

        // Reset with three reads in flight
        bus.rd_req = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("dir_rd_pre_rst", bus.rd_gnt, onehot(k));
            tick();
            bus.rd_req[k] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ctrl", {bus.wr_gnt, bus.rd_gnt, bus.rd_valid, bus.ram_en_wr, bus.ram_en_rd}, '0);
        chk("post_rst_bus", {bus.ram_addr_wr, bus.ram_data_wr, bus.ram_addr_rd}, '0);
        for (int k = 0; k < RDL + 3; k++) begin
            tick();
            @(negedge clk);
            chk("post_rst_no_valid", bus.rd_valid, '0);
        end

        // Write 55 to addr 5, read addr 5 on the next cycle
        tick();
        bus.wr_req[0] = 1'b1;
        bus.wr_addr[0 +: AW] = 4'd5;
        bus.wr_data[0 +: DW] = 8'h55;
        @(negedge clk);
        chk("raw_wr_gnt", bus.wr_gnt, 4'b0001);
        tick();
        bus.wr_req = '0;
        bus.rd_req[1] = 1'b1;
        bus.rd_addr[AW +: AW] = 4'd5;
        @(negedge clk);
`ifdef TP_RAM_ARB_RAW_STALL_EN
        chk("raw_rd_stalled", bus.rd_gnt, 4'b0000);
        tick();
        @(negedge clk);
`endif
        chk("raw_rd_gnt", bus.rd_gnt, 4'b0010);
        tick();
        bus.rd_req = '0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.rd_valid[1]) begin
                got = 1'b1;
                chk("raw_rd_data", bus.rd_data, 8'h55);
            end
        end
        chk("raw_rd_seen", got, 1'b1);
        tick();

        // Random traffic; requests hold until granted
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            gw = bus.wr_gnt;
            gr = bus.rd_gnt;
            for (int i = 0; i < NR; i++) begin
                if (bus.wr_req[i]) begin
                    if (gw[i]) begin chk("wr_wait", wwait[i] < WAIT_BOUND, 1'b1); wwait[i] = 0; end
                    else wwait[i]++;
                end
                if (bus.rd_req[i]) begin
                    if (gr[i]) begin chk("rd_wait", rwait[i] < WAIT_BOUND, 1'b1); rwait[i] = 0; end
                    else rwait[i]++;
                end
            end
            tick();
            for (int i = 0; i < NR; i++) begin
                if (!bus.wr_req[i] || gw[i]) begin
                    bus.wr_req[i] = 1'($urandom_range(0, 1));
                    bus.wr_addr[i*AW +: AW] = AW'($urandom);
                    bus.wr_data[i*DW +: DW] = DW'($urandom);
                end
                if (!bus.rd_req[i] || gr[i]) begin
                    bus.rd_req[i] = 1'($urandom_range(0, 1));
                    bus.rd_addr[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        for (int i = 0; i < NR; i++) begin
            chk("wr_wait_end", wwait[i] < WAIT_BOUND, 1'b1);
            chk("rd_wait_end", rwait[i] < WAIT_BOUND, 1'b1);
        end
        bus.wr_req = '0;
        bus.rd_req = '0;
        repeat (RDL + 4) tick();
        @(negedge clk);
        chk("rdq_drained", rdq.size(), 0);
        chk("wrq_drained", wrq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
